// File: rtl/dmem_req_pkg.sv
// rtl/dmem_req_pkg.sv - shared constants, state encoding and address helper for dmem_req
// Purpose: memop one-hot bit positions, bus size codes, FSM state type and the
//          kseg0/kseg1 virtual-to-physical mapping used by the request stage.
// Ports:   none (package).
package dmem_req_pkg;

  localparam int MMOP = 12;

  localparam int MOP_LB  = 0;
  localparam int MOP_LBU = 1;
  localparam int MOP_LH  = 2;
  localparam int MOP_LHU = 3;
  localparam int MOP_LW  = 4;
  localparam int MOP_SB  = 5;
  localparam int MOP_SH  = 6;
  localparam int MOP_SW  = 7;
  localparam int MOP_LWL = 8;
  localparam int MOP_LWR = 9;
  localparam int MOP_SWL = 10;
  localparam int MOP_SWR = 11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_e;

  // kseg0 and kseg1 (0x8000_0000-0xBFFF_FFFF) both alias physical 0..512MB.
  function automatic logic [31:0] kseg_phys(input logic [31:0] va, input bit map_en);
    if (map_en && (va[31:30] == 2'b10)) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

endpackage

// File: rtl/dmem_req_if.sv
// rtl/dmem_req_if.sv - SRAM-like data bus (req / addr_ok / data_ok) interface
// Purpose: bundles the request-side and response-side signals of the data bus.
// Ports:   master = request stage (drives request fields, receives handshakes/rdata);
//          slave  = memory side.
interface dmem_req_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - combinational size / strobe / store-data alignment
// Purpose: decodes the memop one-hot into bus direction, size, byte strobes and
//          lane-aligned write data.
// Ports:   memop_i, addr_low_i, storedata_i in; wr_o, size_o, wstrb_o, wdata_o,
//          word_align_o (unaligned-word op, address forced to word boundary) out.
module dmem_align
  import dmem_req_pkg::*;
(
  input  logic [MMOP-1:0] memop_i,
  input  logic [1:0]      addr_low_i,
  input  logic [31:0]     storedata_i,
  output logic            wr_o,
  output logic [1:0]      size_o,
  output logic [3:0]      wstrb_o,
  output logic [31:0]     wdata_o,
  output logic            word_align_o
);

  always_comb begin
    wr_o         = memop_i[MOP_SB] | memop_i[MOP_SH] | memop_i[MOP_SW] |
                   memop_i[MOP_SWL] | memop_i[MOP_SWR];
    word_align_o = memop_i[MOP_LWL] | memop_i[MOP_LWR] |
                   memop_i[MOP_SWL] | memop_i[MOP_SWR];
    size_o       = SIZE_WORD;
    wstrb_o      = 4'b0000;
    wdata_o      = storedata_i;

    if (memop_i[MOP_LB] | memop_i[MOP_LBU] | memop_i[MOP_SB]) begin
      size_o = SIZE_BYTE;
    end else if (memop_i[MOP_LH] | memop_i[MOP_LHU] | memop_i[MOP_SH]) begin
      size_o = SIZE_HALF;
    end

    if (memop_i[MOP_SB]) begin
      wstrb_o = 4'b0001 << addr_low_i;
      wdata_o = {4{storedata_i[7:0]}};
    end else if (memop_i[MOP_SH]) begin
      wstrb_o = addr_low_i[1] ? 4'b1100 : 4'b0011;
      wdata_o = {2{storedata_i[15:0]}};
    end else if (memop_i[MOP_SW]) begin
      wstrb_o = 4'b1111;
    end else if (memop_i[MOP_SWL]) begin
      // For a 2-bit offset, 3 - a equals ~a: swl writes the top (a+1) bytes of rt
      // into the low lanes of the word.
      wstrb_o = 4'b1111 >> (~addr_low_i);
      wdata_o = storedata_i >> {~addr_low_i, 3'b000};
    end else if (memop_i[MOP_SWR]) begin
      wstrb_o = 4'b1111 << addr_low_i;
      wdata_o = storedata_i << {addr_low_i, 3'b000};
    end
  end

endmodule

// File: rtl/dmem_req.sv
// rtl/dmem_req.sv - data-memory request stage: one bus transaction per load/store
// Purpose: launches execute-stage memory ops onto the data bus, flags misaligned
//          addresses, captures the read word for load-extract and stalls the
//          pipeline while a transaction is outstanding.
// Ports:   clk, rst (async, active-high); ex_* op inputs; mem_stall_i/mem_flush_i
//          pipeline control; bus (data bus master); mem_memdata_o/mem_memaddr_low_o
//          result; dmem_adel_o/dmem_ades_o/dmem_badvaddr_o address error;
//          dmem_stallreq_o stall request.
module dmem_req
  import dmem_req_pkg::*;
#(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic [MMOP-1:0] ex_memop_i,
  input  logic [31:0]     ex_memaddr_i,
  input  logic [31:0]     ex_storedata_i,
  input  logic            mem_stall_i,
  input  logic            mem_flush_i,
  dmem_req_if.master      bus,
  output logic [31:0]     mem_memdata_o,
  output logic [1:0]      mem_memaddr_low_o,
  output logic            dmem_adel_o,
  output logic            dmem_ades_o,
  output logic [31:0]     dmem_badvaddr_o,
  output logic            dmem_stallreq_o
);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  low_q, low_d;
  logic [31:0] memdata_q, memdata_d;

  logic        al_wr;
  logic [1:0]  al_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic        al_word;

  dmem_align u_align (
    .memop_i      (ex_memop_i),
    .addr_low_i   (ex_memaddr_i[1:0]),
    .storedata_i  (ex_storedata_i),
    .wr_o         (al_wr),
    .size_o       (al_size),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .word_align_o (al_word)
  );

  logic        is_half, is_word, misaligned;
  logic        can_accept, op_valid, addr_err, start;
  logic [31:0] req_vaddr;

  assign is_half    = ex_memop_i[MOP_LH] | ex_memop_i[MOP_LHU] | ex_memop_i[MOP_SH];
  assign is_word    = ex_memop_i[MOP_LW] | ex_memop_i[MOP_SW];
  assign misaligned = (is_half & ex_memaddr_i[0]) | (is_word & (|ex_memaddr_i[1:0]));

  // A new op is taken from IDLE, or straight out of DONE when the completed
  // result is being consumed this cycle (back-to-back issue).
  assign can_accept = (state_q == ST_IDLE) | ((state_q == ST_DONE) & ~mem_stall_i);
  assign op_valid   = ex_valid_i & (|ex_memop_i) & can_accept;
  assign addr_err   = op_valid & misaligned;
  assign start      = op_valid & ~misaligned & ~mem_flush_i;

  assign req_vaddr  = al_word ? {ex_memaddr_i[31:2], 2'b00} : ex_memaddr_i;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    low_d     = low_q;
    memdata_d = memdata_q;

    if (start) begin
      wr_d    = al_wr;
      size_d  = al_size;
      addr_d  = kseg_phys(req_vaddr, KSEG_MAP);
      wdata_d = al_wdata;
      wstrb_d = al_wstrb;
      low_d   = ex_memaddr_i[1:0];
    end

    // A flush kills any result held for load-extract; capture below happens
    // only on non-flush paths so this clear is never overridden.
    if (mem_flush_i) begin
      memdata_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_flush_i) begin
          // Once accepted, the response is still owed and must be swallowed.
          state_d = (bus.data_addr_ok & ~bus.data_data_ok) ? ST_DRAIN : ST_IDLE;
        end else if (bus.data_addr_ok & bus.data_data_ok) begin
          state_d   = ST_DONE;
          memdata_d = bus.data_rdata;
        end else if (bus.data_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_flush_i) begin
          state_d = bus.data_data_ok ? ST_IDLE : ST_DRAIN;
        end else if (bus.data_data_ok) begin
          state_d   = ST_DONE;
          memdata_d = bus.data_rdata;
        end
      end
      ST_DONE: begin
        if (mem_flush_i)     state_d = ST_IDLE;
        else if (mem_stall_i) state_d = ST_DONE;
        else if (start)       state_d = ST_REQ;
        else                  state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.data_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      low_q     <= 2'd0;
      memdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      low_q     <= low_d;
      memdata_q <= memdata_d;
    end
  end

  // Request is a pure decode of the state register, never of bus inputs.
  assign bus.data_req   = (state_q == ST_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign bus.data_wstrb = wstrb_q;

  assign mem_memdata_o     = memdata_q;
  assign mem_memaddr_low_o = low_q;
  assign dmem_adel_o       = addr_err & ~al_wr;
  assign dmem_ades_o       = addr_err & al_wr;
  assign dmem_badvaddr_o   = addr_err ? ex_memaddr_i : 32'd0;
  assign dmem_stallreq_o   = start | (state_q == ST_REQ) | (state_q == ST_WAIT) |
                             (state_q == ST_DRAIN);

endmodule
